// File: rtl/parity_stream_arbiter.sv
// Packet-granular round-robin merge of the odd- and even-parity AXI-Stream outputs
// of the parity filter into one stream, with a wrapping per-source packet count.
module parity_stream_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              a_clk,
    input  logic              axis_aresetn,
    input  logic              axis_s_tvalid_odd,
    input  logic [DATA_W-1:0] axis_s_tdata_odd,
    input  logic              axis_s_tlast_odd,
    output logic              axis_s_tready_odd,
    input  logic              axis_s_tvalid_even,
    input  logic [DATA_W-1:0] axis_s_tdata_even,
    input  logic              axis_s_tlast_even,
    output logic              axis_s_tready_even,
    output logic              axis_m_tvalid,
    output logic [DATA_W-1:0] axis_m_tdata,
    output logic              axis_m_tlast,
    input  logic              axis_m_tready,
    output logic              grant_odd,
    output logic              grant_even,
    output logic [CNT_W-1:0]  pkt_cnt_odd,
    output logic [CNT_W-1:0]  pkt_cnt_even
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GNT_ODD  = 2'd1,
        GNT_EVEN = 2'd2
    } state_t;

    typedef enum logic {
        SRC_ODD  = 1'b0,
        SRC_EVEN = 1'b1
    } src_t;

    state_t state, state_nxt;
    src_t   last_grant, last_grant_nxt;
    logic   eop_odd, eop_even;

    // End of packet: the tlast beat of the owning source actually handshakes.
    assign eop_odd  = (state == GNT_ODD)  && axis_s_tvalid_odd  && axis_m_tready && axis_s_tlast_odd;
    assign eop_even = (state == GNT_EVEN) && axis_s_tvalid_even && axis_m_tready && axis_s_tlast_even;

    // The reset name is inherited from the stream interface, but it is active-high here.
    always_ff @(posedge a_clk or posedge axis_aresetn) begin
        if (axis_aresetn) begin
            state        <= IDLE;
            last_grant   <= SRC_EVEN;
            pkt_cnt_odd  <= '0;
            pkt_cnt_even <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values,
            // so the order of these lines cannot change behaviour.
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            if (eop_odd)
                pkt_cnt_odd <= pkt_cnt_odd + CNT_W'(1);
            if (eop_even)
                pkt_cnt_even <= pkt_cnt_even + CNT_W'(1);
        end
    end

    always_comb begin
        // NOTE: assigning every output a default first means no path leaves a value held,
        // which is what would otherwise infer a latch.
        state_nxt      = state;
        last_grant_nxt = last_grant;
        case (state)
            IDLE: begin
                if (axis_s_tvalid_odd && axis_s_tvalid_even)
                    state_nxt = (last_grant == SRC_EVEN) ? GNT_ODD : GNT_EVEN;
                else if (axis_s_tvalid_odd)
                    state_nxt = GNT_ODD;
                else if (axis_s_tvalid_even)
                    state_nxt = GNT_EVEN;
            end
            GNT_ODD: begin
                if (eop_odd) begin
                    last_grant_nxt = SRC_ODD;
                    state_nxt      = axis_s_tvalid_even ? GNT_EVEN : IDLE;
                end
            end
            GNT_EVEN: begin
                if (eop_even) begin
                    last_grant_nxt = SRC_EVEN;
                    state_nxt      = axis_s_tvalid_odd ? GNT_ODD : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Zero-latency pass-through of the owning source; data is masked while it is not valid.
    always_comb begin
        axis_m_tvalid      = 1'b0;
        axis_m_tdata       = '0;
        axis_m_tlast       = 1'b0;
        axis_s_tready_odd  = 1'b0;
        axis_s_tready_even = 1'b0;
        grant_odd          = 1'b0;
        grant_even         = 1'b0;
        case (state)
            GNT_ODD: begin
                grant_odd         = 1'b1;
                axis_s_tready_odd = axis_m_tready;
                axis_m_tvalid     = axis_s_tvalid_odd;
                if (axis_s_tvalid_odd) begin
                    axis_m_tdata = axis_s_tdata_odd;
                    axis_m_tlast = axis_s_tlast_odd;
                end
            end
            GNT_EVEN: begin
                grant_even         = 1'b1;
                axis_s_tready_even = axis_m_tready;
                axis_m_tvalid      = axis_s_tvalid_even;
                if (axis_s_tvalid_even) begin
                    axis_m_tdata = axis_s_tdata_even;
                    axis_m_tlast = axis_s_tlast_even;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_parity_stream_arbiter.sv
// Self-checking bench: packet-level ownership model plus directed scenarios and random traffic;
// a second instance with CNT_W=2 shares the stimulus to exercise counter wrap.
module tb_parity_stream_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct packed {
        logic [7:0]  data;
        logic        last;
        logic        src;
        logic [31:0] cyc;
    } obeat_t;

    logic       a_clk = 1'b0;
    logic       rst;
    logic [1:0] sv;
    logic [1:0] sl;
    logic [7:0] sd [2];
    logic       m_rdy;

    logic        tr_o, tr_e, mv, ml, go, ge;
    logic [7:0]  md;
    logic [15:0] co, ce;
    logic        tr_o2, tr_e2, mv2, ml2, go2, ge2;
    logic [7:0]  md2;
    logic [1:0]  co2, ce2;

    always #5 a_clk = ~a_clk;

    parity_stream_arbiter dut (
        .a_clk(a_clk), .axis_aresetn(rst),
        .axis_s_tvalid_odd(sv[0]), .axis_s_tdata_odd(sd[0]), .axis_s_tlast_odd(sl[0]),
        .axis_s_tready_odd(tr_o),
        .axis_s_tvalid_even(sv[1]), .axis_s_tdata_even(sd[1]), .axis_s_tlast_even(sl[1]),
        .axis_s_tready_even(tr_e),
        .axis_m_tvalid(mv), .axis_m_tdata(md), .axis_m_tlast(ml), .axis_m_tready(m_rdy),
        .grant_odd(go), .grant_even(ge), .pkt_cnt_odd(co), .pkt_cnt_even(ce)
    );

    parity_stream_arbiter #(.DATA_W(8), .CNT_W(2)) dut_cw2 (
        .a_clk(a_clk), .axis_aresetn(rst),
        .axis_s_tvalid_odd(sv[0]), .axis_s_tdata_odd(sd[0]), .axis_s_tlast_odd(sl[0]),
        .axis_s_tready_odd(tr_o2),
        .axis_s_tvalid_even(sv[1]), .axis_s_tdata_even(sd[1]), .axis_s_tlast_even(sl[1]),
        .axis_s_tready_even(tr_e2),
        .axis_m_tvalid(mv2), .axis_m_tdata(md2), .axis_m_tlast(ml2), .axis_m_tready(m_rdy),
        .grant_odd(go2), .grant_even(ge2), .pkt_cnt_odd(co2), .pkt_cnt_even(ce2)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: who owns the output, who won last, packets completed per source.
    int owner;        // -1 none, 0 odd, 1 even
    int last_src;
    int cnt [2];
    int cyc;
    bit cnt_sample;

    beat_t       src_q [2][$];
    obeat_t      out_log[$];
    logic [13:0] dut_log[$];
    logic [1:0]  cnt_hist[$];
    logic        rdy_plan[$];
    int          valid_pct [2];
    int          ready_pct;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Output vector layout: grant_odd, grant_even, tready_odd, tready_even, tvalid, tlast, tdata.
    function automatic logic [13:0] act_main();
        return {go, ge, tr_o, tr_e, mv, ml, md};
    endfunction

    function automatic logic [13:0] act_cw2();
        return {go2, ge2, tr_o2, tr_e2, mv2, ml2, md2};
    endfunction

    function automatic logic [13:0] exp_outs();
        logic [13:0] e;
        int x;
        e = '0;
        if (owner >= 0) begin
            x = owner;
            e[13]  = (x == 0);
            e[12]  = (x == 1);
            e[11]  = (x == 0) && m_rdy;
            e[10]  = (x == 1) && m_rdy;
            e[9]   = sv[x];
            e[8]   = sv[x] && sl[x];
            e[7:0] = sv[x] ? sd[x] : 8'h00;
        end
        return e;
    endfunction

    task automatic add_packet(input int s, input int len, input logic [7:0] base, input bit rnd);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.data = rnd ? 8'($urandom) : base + 8'(i);
            b.last = (i == len - 1);
            src_q[s].push_back(b);
        end
    endtask

    task automatic compare_and_advance();
        logic [13:0] exp;
        obeat_t      ob;
        int          x;
        exp = exp_outs();
        check("outs", 64'(act_main()), 64'(exp));
        check("outs_cw2", 64'(act_cw2()), 64'(exp));
        check("cnt_odd", 64'(co), 64'(cnt[0] % 65536));
        check("cnt_even", 64'(ce), 64'(cnt[1] % 65536));
        check("cnt_odd_cw2", 64'(co2), 64'(cnt[0] % 4));
        check("cnt_even_cw2", 64'(ce2), 64'(cnt[1] % 4));
        if (cnt_sample) begin
            cnt_hist.push_back(ce2);
            cnt_sample = 1'b0;
        end
        dut_log.push_back(act_main());
        if (owner < 0) begin
            if (sv[0] && sv[1]) owner = (last_src == 1) ? 0 : 1;
            else if (sv[0])     owner = 0;
            else if (sv[1])     owner = 1;
        end else begin
            x = owner;
            if (sv[x] && m_rdy) begin
                void'(src_q[x].pop_front());
                ob.data = sd[x];
                ob.last = sl[x];
                ob.src  = x[0];
                ob.cyc  = 32'(cyc);
                out_log.push_back(ob);
                if (sl[x]) begin
                    cnt[x]++;
                    last_src = x;
                    if (x == 1) cnt_sample = 1'b1;
                    owner = sv[1 - x] ? 1 - x : -1;
                end
            end
        end
        cyc++;
    endtask

    // Called at posedge+1: drive one cycle of stimulus, check at the falling edge.
    task automatic step();
        for (int s = 0; s < 2; s++) begin
            if (src_q[s].size() > 0 && $urandom_range(99) < valid_pct[s]) begin
                sv[s] = 1'b1;
                sd[s] = src_q[s][0].data;
                sl[s] = src_q[s][0].last;
            end else begin
                sv[s] = 1'b0;
                sd[s] = 8'($urandom);
                sl[s] = 1'($urandom);
            end
        end
        if (rdy_plan.size() > 0) m_rdy = rdy_plan.pop_front();
        else                     m_rdy = ($urandom_range(99) < ready_pct);
        @(negedge a_clk);
        compare_and_advance();
        @(posedge a_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sv = '0;
        sl = '0;
        sd[0] = 8'h00;
        sd[1] = 8'h00;
        m_rdy = 1'b0;
        #1;
        check("rst_outs", 64'(act_main()), 64'd0);
        check("rst_cnts", {co2, ce2, co, ce}, 64'd0);
        @(posedge a_clk);
        #1;
        owner = -1;
        last_src = 1;
        cnt[0] = 0;
        cnt[1] = 0;
        cyc = 0;
        cnt_sample = 1'b0;
        src_q[0].delete();
        src_q[1].delete();
        out_log.delete();
        dut_log.delete();
        cnt_hist.delete();
        rdy_plan.delete();
        valid_pct[0] = 100;
        valid_pct[1] = 100;
        ready_pct = 100;
        rst = 1'b0;
    endtask

    int exp_hist [5] = '{1, 2, 3, 0, 1};

    initial begin
        rst = 1'b0;
        sv = '0;
        sl = '0;
        sd[0] = 8'h00;
        sd[1] = 8'h00;
        m_rdy = 1'b0;
        #1;
        do_reset();

        // Single 3-beat odd packet, even idle.
        add_packet(0, 3, 8'h01, 1'b0);
        src_q[0][2].data = 8'h83;
        repeat (6) step();
        check("t1_grant_c0", 64'(dut_log[0][13]), 64'd0);
        check("t1_grant_c1", 64'(dut_log[1][13]), 64'd1);
        check("t1_nbeats", 64'(out_log.size()), 64'd3);
        if (out_log.size() == 3) begin
            check("t1_beat0", {out_log[0].data, out_log[0].last}, {8'h01, 1'b0});
            check("t1_beat1", {out_log[1].data, out_log[1].last}, {8'h02, 1'b0});
            check("t1_beat2", {out_log[2].data, out_log[2].last}, {8'h83, 1'b1});
        end
        check("t1_cnt_odd", 64'(co), 64'd1);
        check("t1_idle", 64'(dut_log[4]), 64'd0);

        // Both sources streaming 2-beat packets: strict alternation, no bubbles.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            add_packet(0, 2, 8'h10 + 8'(2 * p), 1'b0);
            add_packet(1, 2, 8'h20 + 8'(2 * p), 1'b0);
        end
        repeat (9) step();
        check("t2_nbeats", 64'(out_log.size()), 64'd8);
        for (int i = 0; i < 8 && i < out_log.size(); i++) begin
            check("t2_src", 64'(out_log[i].src), 64'((i / 2) % 2));
            check("t2_cyc", 64'(out_log[i].cyc), 64'(i + 1));
        end
        check("t2_cnt_odd", 64'(co), 64'd2);
        check("t2_cnt_even", 64'(ce), 64'd2);

        // Downstream stall mid-packet while even waits.
        do_reset();
        add_packet(0, 4, 8'h40, 1'b0);
        add_packet(1, 2, 8'h50, 1'b0);
        rdy_plan = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        repeat (12) step();
        for (int c = 2; c <= 6; c++)
            check("t3_stall", 64'(dut_log[c]), 64'({6'b100010, 8'h41}));
        check("t3_nbeats", 64'(out_log.size()), 64'd6);
        if (out_log.size() == 6) begin
            for (int i = 0; i < 4; i++)
                check("t3_odd_beat", {out_log[i].src, out_log[i].data}, {1'b0, 8'h40 + 8'(i)});
            check("t3_resume_cyc", 64'(out_log[1].cyc), 64'd7);
            check("t3_even_beat", {out_log[4].src, out_log[4].data}, {1'b1, 8'h50});
        end

        // Back-to-back single-beat odd packets: one bubble each.
        do_reset();
        for (int p = 0; p < 4; p++) add_packet(0, 1, 8'hA0 + 8'(p), 1'b0);
        repeat (9) step();
        check("t4_nbeats", 64'(out_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < out_log.size(); i++)
            check("t4_cyc", 64'(out_log[i].cyc), 64'(2 * i + 1));
        check("t4_cnt_odd", 64'(co), 64'd4);

        // Asynchronous reset in the middle of an even packet.
        do_reset();
        add_packet(1, 1, 8'h55, 1'b0);
        add_packet(1, 6, 8'h60, 1'b0);
        repeat (5) step();
        check("t5_pre_grant", 64'(ge), 64'd1);
        check("t5_pre_cnt", 64'(ce), 64'd1);
        for (int s = 0; s < 2; s++) begin
            sv[s] = (s == 1);
            sd[s] = 8'h61;
            sl[s] = 1'b0;
        end
        m_rdy = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("t5_async_outs", 64'(act_main()), 64'd0);
        check("t5_async_cnts", {co2, ce2, co, ce}, 64'd0);
        do_reset();
        add_packet(0, 2, 8'h71, 1'b0);
        add_packet(1, 2, 8'h81, 1'b0);
        repeat (4) step();
        check("t5_first_src", out_log.size() > 0 ? {out_log[0].src, out_log[0].data} : 9'h1FF,
              {1'b0, 8'h71});

        // Narrow counter wraps after four even packets.
        do_reset();
        for (int p = 0; p < 5; p++) add_packet(1, 1, 8'h90 + 8'(p), 1'b0);
        repeat (12) step();
        check("t6_nsamples", 64'(cnt_hist.size()), 64'd5);
        for (int i = 0; i < 5 && i < cnt_hist.size(); i++)
            check("t6_cnt_even_cw2", 64'(cnt_hist[i]), 64'(exp_hist[i]));

        // Random traffic, random backpressure and bursty valids.
        for (int run = 0; run < 4; run++) begin
            do_reset();
            valid_pct[0] = $urandom_range(100, 40);
            valid_pct[1] = $urandom_range(100, 40);
            ready_pct    = $urandom_range(100, 50);
            for (int k = 0; k < 1000; k++) begin
                for (int s = 0; s < 2; s++)
                    if (src_q[s].size() < 3 && $urandom_range(3) != 0)
                        add_packet(s, $urandom_range(5, 1), 8'h00, 1'b1);
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
